// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE pipeline: memwrite codes, stage states, default widths.
package simple_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned REG_AW_DEFAULT = 3;

    localparam logic [1:0] MEMWRITE_NONE  = 2'b00;
    localparam logic [1:0] MEMWRITE_READ  = 2'b01;
    localparam logic [1:0] MEMWRITE_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        WB
    } state_e;

    // Code 11 is reserved and behaves like a plain ALU/nop bundle.
    function automatic logic [1:0] norm_memwrite(input logic [1:0] code);
        return (code == 2'b11) ? MEMWRITE_NONE : code;
    endfunction

    // State entered when a bundle with the given (normalised) code is accepted.
    function automatic state_e accept_state(input logic [1:0] code);
        case (code)
            MEMWRITE_READ:  return RD;
            MEMWRITE_WRITE: return WR;
            default:        return WB;
        endcase
    endfunction

endpackage

// File: rtl/p4_ack_timer.sv
// Wait-cycle counter for the memory handshake; flags the last allowed cycle.
module p4_ack_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] count_q;

    // Count waiting cycles, saturating at LIMIT; clear wins over enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CW'(LIMIT))) begin
            count_q <= count_q + CW'(1);
        end
    end

    // High in the waiting cycle whose completion brings the count to LIMIT.
    // LIMIT == 0 disables the timeout entirely.
    assign expire = (LIMIT != 0) && enable && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/p4_mem_writeback.sv
// Memory-access / writeback stage: one req/ack data-memory transaction, then a
// single-cycle register-file write. Stalls upstream while memory is busy.
module p4_mem_writeback
    import simple_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned REG_AW      = REG_AW_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_writereg,
    input  logic [1:0]        in_memwrite,
    input  logic [REG_AW-1:0] in_regaddress,
    input  logic [DATA_W-1:0] in_address,
    input  logic [DATA_W-1:0] in_storedata,
    input  logic [DATA_W-1:0] in_aluresult,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              writeflag,
    output logic [REG_AW-1:0] writetarget,
    output logic [DATA_W-1:0] readoutwriteval,
    output logic [DATA_W-1:0] aluwriteval,
    output logic              readoutSelect,
    output logic              mem_err
);

    state_e state_q, state_d;

    logic accept;
    logic waiting;
    logic expire;
    logic abort;
    logic [1:0] in_kind;

    // Latched bundle.
    logic              lat_writereg;
    logic [1:0]        lat_kind;
    logic [REG_AW-1:0] lat_reg;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] lat_alu;

    // Write-port data, updated only on entry to WB so it holds elsewhere.
    logic [REG_AW-1:0] target_q;
    logic [DATA_W-1:0] rdval_q;
    logic [DATA_W-1:0] aluval_q;
    logic              err_q;

    assign in_kind  = norm_memwrite(in_memwrite);
    assign waiting  = (state_q == RD) || (state_q == WR);
    assign in_ready = (state_q == IDLE) || (state_q == WB);
    assign accept   = in_valid && in_ready;
    // A late ack in the final allowed cycle still completes the transaction.
    assign abort    = expire && !mem_ack;

    p4_ack_timer #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (accept),
        .enable  (waiting),
        .expire  (expire)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = accept_state(in_kind);
            end
            WB: begin
                state_d = accept ? accept_state(in_kind) : IDLE;
            end
            RD, WR: begin
                if (mem_ack)    state_d = WB;
                else if (abort) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the incoming bundle on accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_writereg <= 1'b0;
            lat_kind     <= MEMWRITE_NONE;
            lat_reg      <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_alu      <= '0;
        end else if (accept) begin
            lat_writereg <= in_writereg;
            lat_kind     <= in_kind;
            lat_reg      <= in_regaddress;
            lat_addr     <= in_address;
            lat_wdata    <= in_storedata;
            lat_alu      <= in_aluresult;
        end
    end

    // Load write-port data on the transition into WB; raise mem_err after an abort.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= '0;
            rdval_q  <= '0;
            aluval_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= waiting && abort;
            if (accept && (in_kind == MEMWRITE_NONE)) begin
                // ALU/nop bundles go straight to WB, so take data from the inputs.
                target_q <= in_regaddress;
                aluval_q <= in_aluresult;
            end else if (waiting && mem_ack) begin
                target_q <= lat_reg;
                aluval_q <= lat_alu;
                if (state_q == RD) rdval_q <= mem_rdata;
            end
        end
    end

    // Memory port: purely state-derived so reset drops mem_req immediately.
    assign mem_req   = waiting;
    assign mem_we    = (state_q == WR);
    assign mem_addr  = waiting ? lat_addr : '0;
    assign mem_wdata = waiting ? lat_wdata : '0;

    // Register-file write port.
    assign writeflag       = (state_q == WB) && lat_writereg && (lat_kind != MEMWRITE_WRITE);
    assign readoutSelect   = (state_q == WB) && (lat_kind == MEMWRITE_READ);
    assign writetarget     = target_q;
    assign readoutwriteval = rdval_q;
    assign aluwriteval     = aluval_q;
    assign mem_err         = err_q;

endmodule
